// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Mode encodings and the channel-select width used by the top-level decode.
package clock_divider_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow divisor pair, and registered
// slow-clock, tick and pending outputs.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int          CNT_W     = 24,
  parameter int unsigned DIV_RESET = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             sync_restart,
  output logic             slw_clk,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_shadow;
  logic             wrap;

  // >= rather than == so a held count left above a smaller divisor
  // (applied while disabled) still wraps on the next enabled edge.
  assign wrap = enable && (cnt >= div_active);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      div_active <= DIV_INIT;
      div_shadow <= DIV_INIT;
      slw_clk    <= 1'b0;
      tick       <= 1'b0;
      pending    <= 1'b0;
    end else if (sync_restart) begin
      cnt     <= '0;
      slw_clk <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (load) begin
        div_active <= load_data;
        div_shadow <= load_data;
      end else if (pending) begin
        div_active <= div_shadow;
      end
    end else begin
      if (enable) begin
        if (wrap) begin
          cnt     <= '0;
          tick    <= 1'b1;
          slw_clk <= (mode == MODE_TOGGLE) ? ~slw_clk : 1'b0;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
          if (mode == MODE_PULSE) slw_clk <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        if (mode == MODE_PULSE) slw_clk <= 1'b0;
      end

      // A write on a wrap edge stays pending so the period just started
      // keeps the divisor it began with.
      if (load) begin
        div_shadow <= load_data;
        pending    <= 1'b1;
      end else if (pending && (wrap || !enable)) begin
        div_active <= div_shadow;
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: decodes divisor writes to one
// channel and fans the phase-align strobe out to every channel.
module multi_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 24,
  parameter int unsigned DIV_RESET = 10000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         mode,
  input  logic                      load_div,
  input  logic [ch_w(NUM_CH)-1:0]   load_ch,
  input  logic [CNT_W-1:0]          load_data,
  input  logic                      sync_restart,
  output logic [NUM_CH-1:0]         slw_clk,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] load_sel;

  // Only indices below NUM_CH are decoded, so out-of-range selects hit nothing.
  always_comb begin
    load_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_sel[i] = load_div && (load_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable[i]),
      .mode         (mode[i]),
      .load         (load_sel[i]),
      .load_data    (load_data),
      .sync_restart (sync_restart),
      .slw_clk      (slw_clk[i]),
      .tick         (tick[i]),
      .pending      (pending[i])
    );
  end

endmodule
